// File: rtl/program_counter_pkg.sv
// Shared parameters for the program counter: address width, op encodings and FSM states.
package program_counter_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [2:0] OP_STEP       = 3'd0;
    localparam logic [2:0] OP_JUMP       = 3'd1;
    localparam logic [2:0] OP_CALL       = 3'd2;
    localparam logic [2:0] OP_RET        = 3'd3;
    localparam logic [2:0] OP_SOFT_RESET = 3'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/program_counter_return_stack.sv
// LIFO of return addresses; the write pointer is the occupancy count itself.
module return_stack
    import program_counter_pkg::*;
#(
    parameter int WORD_WIDTH  = program_counter_pkg::WORD_WIDTH,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           clear,
    input  logic [WORD_WIDTH-1:0]          din,
    output logic [WORD_WIDTH-1:0]          dout,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W + 1)'(STACK_DEPTH);
    localparam logic [PTR_W:0] ONE       = (PTR_W + 1)'(1);

    logic [WORD_WIDTH-1:0] entry [STACK_DEPTH];
    logic [PTR_W:0]        depth_q;
    logic [PTR_W:0]        top_idx;

    assign top_idx = depth_q - ONE;
    assign dout    = entry[top_idx[PTR_W-1:0]];
    assign depth   = depth_q;
    assign full    = (depth_q == DEPTH_MAX);
    assign empty   = (depth_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
        end else if (clear) begin
            depth_q <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + ONE;
        end else if (pop && !empty) begin
            depth_q <= depth_q - ONE;
        end
    end

    // Entries are never cleared; only the pointer decides what is valid.
    always_ff @(posedge clk) begin
        if (!clear && push && !full) begin
            entry[depth_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Fetch-address register with relative step, jump, call/return stack and sticky misuse fault.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int                           WORD_WIDTH   = program_counter_pkg::WORD_WIDTH,
    parameter int                           STACK_DEPTH  = 8,
    parameter logic [WORD_WIDTH-1:0]        RESET_VECTOR = '0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [2:0]                      op,
    input  logic [WORD_WIDTH-1:0]           adj,
    input  logic [WORD_WIDTH-1:0]           target,
    output logic [WORD_WIDTH-1:0]           pc,
    output logic [$clog2(STACK_DEPTH):0]    depth,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            fault
);

    localparam logic [WORD_WIDTH-1:0] PC_ONE = WORD_WIDTH'(1);

    pc_state_e             state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop, clear;
    logic [WORD_WIDTH-1:0] stack_dout;
    logic                  stack_full, stack_empty;

    return_stack #(
        .WORD_WIDTH (WORD_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_return_stack (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .clear  (clear),
        .din    (pc_q + PC_ONE),
        .dout   (stack_dout),
        .depth  (depth),
        .full   (stack_full),
        .empty  (stack_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_VECTOR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // SOFT_RESET is honoured in either state; everything else only in RUN.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        pop         = 1'b0;
        clear       = 1'b0;
        if (enable) begin
            if (op == OP_SOFT_RESET) begin
                state_d     = ST_RUN;
                pc_d        = RESET_VECTOR;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                clear       = 1'b1;
            end else if (state_q == ST_RUN) begin
                case (op)
                    OP_STEP: pc_d = pc_q + adj;
                    OP_JUMP: pc_d = target;
                    OP_CALL: begin
                        if (stack_full) begin
                            overflow_d = 1'b1;
                            state_d    = ST_FAULT;
                        end else begin
                            push = 1'b1;
                            pc_d = target;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            underflow_d = 1'b1;
                            state_d     = ST_FAULT;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stack_dout;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pc        = pc_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign fault     = overflow_q | underflow_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a 4-entry stack and reset vector 0x0100.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] adj = 16'h0;
    logic [15:0] target = 16'h0;
    logic [15:0] pc;
    logic [2:0]  depth;
    logic        overflow, underflow, fault;

    int vectors = 0;
    int miscompares = 0;

    program_counter #(
        .WORD_WIDTH  (16),
        .STACK_DEPTH (4),
        .RESET_VECTOR(16'h0100)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .op       (op),
        .adj      (adj),
        .target   (target),
        .pc       (pc),
        .depth    (depth),
        .overflow (overflow),
        .underflow(underflow),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // Apply one op across one rising edge, then settle 1ns past it.
    task automatic do_op(input logic en, input logic [2:0] o, input logic [15:0] a, input logic [15:0] t);
        enable = en;
        op     = o;
        adj    = a;
        target = t;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (pc !== 16'h0100 || depth !== 3'd0 || fault !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: pc=%h depth=%0d ovf=%b unf=%b fault=%b, want pc=0100 depth=0 flags=0", pc, depth, overflow, underflow, fault);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_step();
        logic [15:0] exp_pc [3] = '{16'h0101, 16'h0102, 16'h0103};
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 3'd0, 16'h0001, 16'h0);
            vectors++;
            if (pc !== exp_pc[i]) begin
                miscompares++;
                $display("FAIL step%0d: pc=%h want %h", i, pc, exp_pc[i]);
            end
        end
        do_op(1'b1, 3'd0, 16'hFFFE, 16'h0);
        vectors++;
        if (pc !== 16'h0101) begin
            miscompares++;
            $display("FAIL step_neg2: pc=%h want 0101", pc);
        end
        do_op(1'b0, 3'd1, 16'h0, 16'h1234);
        do_op(1'b0, 3'd0, 16'h0007, 16'h0);
        vectors++;
        if (pc !== 16'h0101) begin
            miscompares++;
            $display("FAIL enable_hold: pc=%h want 0101", pc);
        end
    endtask

    task automatic test_wrap();
        do_op(1'b1, 3'd1, 16'h0, 16'hFFFF);
        vectors++;
        if (pc !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL jump_ffff: pc=%h want ffff", pc);
        end
        do_op(1'b1, 3'd0, 16'h0002, 16'h0);
        vectors++;
        if (pc !== 16'h0001) begin
            miscompares++;
            $display("FAIL wrap_up: pc=%h want 0001", pc);
        end
        do_op(1'b1, 3'd1, 16'h0, 16'h0000);
        do_op(1'b1, 3'd0, 16'hFFFF, 16'h0);
        vectors++;
        if (pc !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_down: pc=%h want ffff", pc);
        end
    endtask

    task automatic test_call_ret();
        do_op(1'b1, 3'd1, 16'h0, 16'h0200);
        do_op(1'b1, 3'd2, 16'h0, 16'h1000);
        do_op(1'b1, 3'd2, 16'h0, 16'h2000);
        do_op(1'b1, 3'd0, 16'h0004, 16'h0);
        vectors++;
        if (pc !== 16'h2004 || depth !== 3'd2) begin
            miscompares++;
            $display("FAIL nested_call: pc=%h depth=%0d want pc=2004 depth=2", pc, depth);
        end
        do_op(1'b1, 3'd3, 16'h0, 16'h0);
        vectors++;
        if (pc !== 16'h1001 || depth !== 3'd1) begin
            miscompares++;
            $display("FAIL ret1: pc=%h depth=%0d want pc=1001 depth=1", pc, depth);
        end
        do_op(1'b1, 3'd3, 16'h0, 16'h0);
        vectors++;
        if (pc !== 16'h0201 || depth !== 3'd0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL ret2: pc=%h depth=%0d fault=%b want pc=0201 depth=0 fault=0", pc, depth, fault);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] tgts [4] = '{16'h3000, 16'h3100, 16'h3200, 16'h3300};
        for (int i = 0; i < 4; i++) do_op(1'b1, 3'd2, 16'h0, tgts[i]);
        vectors++;
        if (pc !== 16'h3300 || depth !== 3'd4 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL four_calls: pc=%h depth=%0d fault=%b want pc=3300 depth=4 fault=0", pc, depth, fault);
        end
        do_op(1'b1, 3'd2, 16'h0, 16'h4000);
        vectors++;
        if (pc !== 16'h3300 || depth !== 3'd4 || overflow !== 1'b1 || underflow !== 1'b0 || fault !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: pc=%h depth=%0d ovf=%b unf=%b fault=%b want pc=3300 depth=4 ovf=1 unf=0 fault=1",
                     pc, depth, overflow, underflow, fault);
        end
        do_op(1'b1, 3'd1, 16'h0, 16'h5555);
        do_op(1'b1, 3'd0, 16'h0001, 16'h0);
        do_op(1'b1, 3'd3, 16'h0, 16'h0);
        vectors++;
        if (pc !== 16'h3300 || depth !== 3'd4 || fault !== 1'b1 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_hold: pc=%h depth=%0d fault=%b unf=%b want pc=3300 depth=4 fault=1 unf=0", pc, depth, fault, underflow);
        end
        do_op(1'b1, 3'd4, 16'h0, 16'h0);
        vectors++;
        if (pc !== 16'h0100 || depth !== 3'd0 || overflow !== 1'b0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL soft_reset: pc=%h depth=%0d ovf=%b fault=%b want pc=0100 depth=0 flags=0", pc, depth, overflow, fault);
        end
    endtask

    task automatic test_underflow();
        do_op(1'b1, 3'd1, 16'h0, 16'h0777);
        do_op(1'b1, 3'd3, 16'h0, 16'h0);
        vectors++;
        if (pc !== 16'h0777 || depth !== 3'd0 || underflow !== 1'b1 || overflow !== 1'b0 || fault !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow: pc=%h depth=%0d unf=%b ovf=%b fault=%b want pc=0777 depth=0 unf=1 ovf=0 fault=1",
                     pc, depth, underflow, overflow, fault);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (pc !== 16'h0100 || underflow !== 1'b0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: pc=%h unf=%b fault=%b want pc=0100 unf=0 fault=0", pc, underflow, fault);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_nop_gating();
        do_op(1'b1, 3'd1, 16'h0, 16'h0ABC);
        do_op(1'b1, 3'd2, 16'h0, 16'h0B00);
        for (int o = 5; o < 8; o++) begin
            do_op(1'b1, 3'(o), 16'h0011, 16'h2222);
            vectors++;
            if (pc !== 16'h0B00 || depth !== 3'd1 || fault !== 1'b0) begin
                miscompares++;
                $display("FAIL nop%0d: pc=%h depth=%0d fault=%b want pc=0b00 depth=1 fault=0", o, pc, depth, fault);
            end
        end
        do_op(1'b0, 3'd4, 16'h0, 16'h0);
        vectors++;
        if (pc !== 16'h0B00 || depth !== 3'd1) begin
            miscompares++;
            $display("FAIL gated_soft_reset: pc=%h depth=%0d want pc=0b00 depth=1", pc, depth);
        end
        do_op(1'b1, 3'd3, 16'h0, 16'h0);
        vectors++;
        if (pc !== 16'h0ABD || depth !== 3'd0) begin
            miscompares++;
            $display("FAIL ret_after_nops: pc=%h depth=%0d want pc=0abd depth=0", pc, depth);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_nop_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
